// File: rtl/axioma_int_ctrl_if.sv
// CPU-side interrupt handshake for axioma_int_ctrl.
// master: the CPU core (drives qualifiers and acknowledges).
// slave : the interrupt controller (presents request and vector).
interface axioma_int_ctrl_if;
  logic       global_ie;
  logic       insn_boundary;
  logic       irq_ack;
  logic       reti;
  logic       irq_req;
  logic [4:0] irq_vector;
  logic       in_service;

  modport master (
    output global_ie, insn_boundary, irq_ack, reti,
    input  irq_req, irq_vector, in_service
  );

  modport slave (
    input  global_ie, insn_boundary, irq_ack, reti,
    output irq_req, irq_vector, in_service
  );
endinterface

// File: rtl/axioma_int_ctrl.sv
// axioma_int_ctrl: fixed-priority interrupt controller (source i -> vector i+1,
// index 0 highest). IDLE -> PEND on a qualified instruction boundary, PEND ->
// SERVICE on CPU ack (one-cycle flag-clear pulse), SERVICE -> IDLE on RETI.
// Optional macro AXIOMA_INT_SYNC_EN adds a 2-flop synchronizer on irq_lines
// ahead of the request sample register.
module axioma_int_ctrl #(
  parameter int unsigned NUM_IRQ = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_lines,
  axioma_int_ctrl_if.slave   cpu,
  output logic [NUM_IRQ-1:0] irq_clear,
  output logic [1:0]         debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PEND    = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] req_s;
  logic [4:0]         idx_reg;
  logic [4:0]         first_idx;
  logic               any_req;
  logic               irq_req_q;
  logic [4:0]         irq_vector_q;
  logic               in_service_q;

`ifdef AXIOMA_INT_SYNC_EN
  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;

  // Two-flop synchronizer followed by the request sample register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      req_s <= '0;
    end else begin
      sync1 <= irq_lines;
      sync2 <= sync1;
      req_s <= sync2;
    end
  end
`else
  // Request sample register: one cycle of latency on irq_lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_s <= '0;
    else       req_s <= irq_lines;
  end
`endif

  // Fixed-priority pick: scanning downward leaves the lowest active index.
  always_comb begin
    first_idx = '0;
    any_req   = |req_s;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (req_s[i-1]) first_idx = 5'(i - 1);
    end
  end

  // Controller FSM with all CPU-visible outputs registered alongside state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx_reg      <= '0;
      irq_req_q    <= 1'b0;
      irq_vector_q <= '0;
      irq_clear    <= '0;
      in_service_q <= 1'b0;
    end else begin
      irq_clear <= '0;
      case (state)
        IDLE: begin
          if (cpu.global_ie && cpu.insn_boundary && any_req) begin
            idx_reg      <= first_idx;
            irq_vector_q <= first_idx + 5'd1;
            irq_req_q    <= 1'b1;
            state        <= PEND;
          end
        end
        PEND: begin
          // Ack is tested first so it wins over a simultaneous cancel.
          if (cpu.irq_ack) begin
            irq_clear    <= {{(NUM_IRQ-1){1'b0}}, 1'b1} << idx_reg;
            irq_req_q    <= 1'b0;
            irq_vector_q <= '0;
            in_service_q <= 1'b1;
            state        <= SERVICE;
          end else if (!req_s[idx_reg] || !cpu.global_ie) begin
            irq_req_q    <= 1'b0;
            irq_vector_q <= '0;
            state        <= IDLE;
          end
        end
        SERVICE: begin
          if (cpu.reti) begin
            in_service_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          irq_req_q    <= 1'b0;
          irq_vector_q <= '0;
          in_service_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign cpu.irq_req    = irq_req_q;
  assign cpu.irq_vector = irq_vector_q;
  assign cpu.in_service = in_service_q;
  assign debug_state    = state;

endmodule

// File: tb/tb_axioma_int_ctrl.sv
// Directed self-checking bench for axioma_int_ctrl. Expected output snapshots
// are queued as each stimulus step is driven and compared once the DUT has
// responded (1 time unit after the clock edge, or immediately for async reset).
module tb_axioma_int_ctrl;

`ifdef AXIOMA_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] irq_lines;
  logic [24:0] irq_clear;
  logic [1:0]  debug_state;

  axioma_int_ctrl_if cpu ();

  axioma_int_ctrl #(.NUM_IRQ(25)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .irq_lines  (irq_lines),
    .cpu        (cpu),
    .irq_clear  (irq_clear),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        req;
    logic [4:0]  vec;
    logic [24:0] clr;
    logic        insv;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic expect_o(input string tag, input logic req, input logic [4:0] vec,
                          input logic [24:0] clr, input logic insv, input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.req = req; e.vec = vec; e.clr = clr; e.insv = insv; e.st = st;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag);
    expect_o(tag, 1'b0, 5'd0, '0, 1'b0, 2'b00);
  endtask

  task automatic pend(input string tag, input logic [4:0] vec);
    expect_o(tag, 1'b1, vec, '0, 1'b0, 2'b01);
  endtask

  task automatic svc(input string tag, input logic [24:0] clr);
    expect_o(tag, 1'b0, 5'd0, clr, 1'b1, 2'b10);
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".irq_req"},     32'(cpu.irq_req),    32'(e.req));
      cmp({e.tag, ".irq_vector"},  32'(cpu.irq_vector), 32'(e.vec));
      cmp({e.tag, ".irq_clear"},   32'(irq_clear),      32'(e.clr));
      cmp({e.tag, ".in_service"},  32'(cpu.in_service), 32'(e.insv));
      cmp({e.tag, ".debug_state"}, 32'(debug_state),    32'(e.st));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    irq_lines = '0;
    cpu.global_ie = 1'b0;
    cpu.insn_boundary = 1'b0;
    cpu.irq_ack = 1'b0;
    cpu.reti = 1'b0;
    #3;
    idle("reset"); drain();
    @(posedge clk); #1;
    reset = 1'b0;

    // Single source, full handshake: bit 15 -> vector 16.
    irq_lines[15] = 1'b1; cpu.global_ie = 1'b1;
    repeat (LAT) begin idle("t1_sample"); cyc(); end
    cpu.insn_boundary = 1'b1; pend("t1_req", 5'd16); cyc();
    cpu.insn_boundary = 1'b0; pend("t1_hold", 5'd16); cyc();
    cpu.irq_ack = 1'b1; svc("t1_ack", 25'h0008000); cyc();
    cpu.irq_ack = 1'b0; irq_lines = '0;
    svc("t1_svc", '0); cyc();
    cpu.reti = 1'b1; idle("t1_reti"); cyc();
    cpu.reti = 1'b0;

    // Priority between 13 and 15; later bit 2 must not displace the vector.
    irq_lines = 25'h000A000;
    repeat (LAT) begin idle("t2_sample"); cyc(); end
    cpu.insn_boundary = 1'b1; pend("t2_req", 5'd14); cyc();
    cpu.insn_boundary = 1'b0; irq_lines[2] = 1'b1;
    repeat (LAT + 1) begin pend("t2_hold", 5'd14); cyc(); end
    cpu.irq_ack = 1'b1; svc("t2_ack", 25'h0002000); cyc();
    irq_lines = '0;
    svc("t2_ack_ignored", '0); cyc();
    cpu.irq_ack = 1'b0;
    cpu.reti = 1'b1; idle("t2_reti"); cyc();
    cpu.reti = 1'b0;

    // Latched line drops before ack: cancel without a clear pulse.
    irq_lines = 25'h0000080;
    repeat (LAT) begin idle("t3_sample"); cyc(); end
    cpu.insn_boundary = 1'b1; pend("t3_req", 5'd8); cyc();
    cpu.insn_boundary = 1'b0; irq_lines = '0;
    repeat (LAT) begin pend("t3_still", 5'd8); cyc(); end
    idle("t3_cancel"); cyc();
    idle("t3_noclr"); cyc();

    // Ack coinciding with a cancel condition: ack wins.
    irq_lines = 25'h0000020;
    repeat (LAT) begin idle("t3b_sample"); cyc(); end
    cpu.insn_boundary = 1'b1; pend("t3b_req", 5'd6); cyc();
    cpu.insn_boundary = 1'b0; irq_lines = '0;
    repeat (LAT) begin pend("t3b_still", 5'd6); cyc(); end
    cpu.irq_ack = 1'b1; svc("t3b_ack_wins", 25'h0000020); cyc();
    cpu.irq_ack = 1'b0;
    cpu.reti = 1'b1; idle("t3b_reti"); cyc();
    cpu.reti = 1'b0;

    // Masked by global_ie across boundaries, then enabled; ie drop cancels PEND.
    cpu.global_ie = 1'b0; irq_lines = 25'h0000008;
    repeat (LAT) begin idle("t4_sample"); cyc(); end
    cpu.insn_boundary = 1'b1;
    repeat (3) begin idle("t4_masked"); cyc(); end
    cpu.global_ie = 1'b1; pend("t4_req", 5'd4); cyc();
    cpu.insn_boundary = 1'b0; cpu.global_ie = 1'b0;
    idle("t4_ie_cancel"); cyc();
    cpu.global_ie = 1'b1;

    // Index 0 beats everything else.
    irq_lines = 25'h1000009;
    repeat (LAT) begin idle("t5_sample"); cyc(); end
    cpu.insn_boundary = 1'b1; pend("t5_prio", 5'd1); cyc();
    cpu.insn_boundary = 1'b0;
    cpu.irq_ack = 1'b1; svc("t5_ack", 25'h0000001); cyc();
    cpu.irq_ack = 1'b0; irq_lines = '0;

    // Asynchronous reset during SERVICE, then spurious reti/ack.
    reset = 1'b1; #1;
    idle("r1_async"); drain();
    idle("r1_hold"); cyc();
    reset = 1'b0;
    cpu.reti = 1'b1; idle("r1_reti_ignored"); cyc();
    cpu.reti = 1'b0;
    cpu.irq_ack = 1'b1; idle("r1_ack_ignored"); cyc();
    cpu.irq_ack = 1'b0;

    // Asynchronous reset during PEND: request dropped, no clear pulse.
    irq_lines = 25'h0000200;
    repeat (LAT) begin idle("r2_sample"); cyc(); end
    cpu.insn_boundary = 1'b1; pend("r2_req", 5'd10); cyc();
    cpu.insn_boundary = 1'b0;
    reset = 1'b1; #1;
    idle("r2_async"); drain();
    idle("r2_hold"); cyc();
    reset = 1'b0;
    repeat (LAT + 1) begin idle("r2_dropped"); cyc(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
